mont_arbiter: RTL and testbench

- Shares one Montgomery multiplier core (start/done/out_read protocol, 381-bit operands) between two requesters, e.g. the point-add and point-double sequencers of the ECDSA verify datapath.
- Registers the granted operand set, runs one multiplication at a time on the core, and returns the result to the requester that issued it.
- Uses round-robin priority when both requesters are valid.

---
 rtl/mont_arbiter.sv | 138 +++++++++++++
 tb/tb_mont_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mont_arbiter.sv
// mont_arbiter: shares one Montgomery multiplier core between two
// requesters, one operation in flight, round-robin on contention.
// Ports: clk, reset (async, active high); req0/req1 valid/ready plus
// a/b/m operands; rsp0/rsp1 valid/ready with shared rsp_result;
// mm_start/mm_a/mm_b/mm_m/mm_result/mm_done/mm_out_read to the core.
// Optional MONT_ARB_STATS_EN adds stat_ops0, stat_ops1, stat_busy.
module mont_arbiter #(
    parameter int WIDTH = 381
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req0_m,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [WIDTH-1:0] req1_m,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             mm_start,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_m,
    input  logic [WIDTH-1:0] mm_result,
    input  logic             mm_done,
    output logic             mm_out_read
`ifdef MONT_ARB_STATS_EN
    ,
    output logic [31:0]      stat_ops0,
    output logic [31:0]      stat_ops1,
    output logic [31:0]      stat_busy
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_next;
    logic   owner;
    logic   last_grant;
    logic   grant0;
    logic   grant1;
    logic   accept;
    logic   rsp_take;

    // Grants are mutually exclusive: on contention the requester
    // that did not win last time is chosen.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
    end

    always_comb begin
        state_next  = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        mm_start    = 1'b0;
        mm_out_read = 1'b0;
        rsp0_valid  = 1'b0;
        rsp1_valid  = 1'b0;
        accept      = 1'b0;
        rsp_take    = 1'b0;
        unique case (state)
            IDLE: begin
                // Masked by reset so no handshake is offered while
                // the block is held in reset.
                req0_ready = grant0 && !reset;
                req1_ready = grant1 && !reset;
                accept     = grant0 || grant1;
                if (accept) state_next = ISSUE;
            end
            ISSUE: begin
                mm_start   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                mm_out_read = mm_done;
                if (mm_done) state_next = RESP;
            end
            RESP: begin
                rsp0_valid = !owner;
                rsp1_valid = owner;
                rsp_take   = owner ? rsp1_ready : rsp0_ready;
                if (rsp_take) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mm_a       <= '0;
            mm_b       <= '0;
            mm_m       <= '0;
            rsp_result <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_next;
            if (accept) begin
                mm_a       <= grant1 ? req1_a : req0_a;
                mm_b       <= grant1 ? req1_b : req0_b;
                mm_m       <= grant1 ? req1_m : req0_m;
                owner      <= grant1;
                last_grant <= grant1;
            end
            if (state == WAIT && mm_done) rsp_result <= mm_result;
        end
    end

`ifdef MONT_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_ops0 <= '0;
            stat_ops1 <= '0;
            stat_busy <= '0;
        end else begin
            if (rsp_take && !owner) stat_ops0 <= stat_ops0 + 32'd1;
            if (rsp_take && owner) stat_ops1 <= stat_ops1 + 32'd1;
            if (state != IDLE) stat_busy <= stat_busy + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mont_arbiter.sv
// tb_mont_arbiter: directed bench with a scoreboard for mont_arbiter.
// Accepts push expected results; a monitor pops them on rsp handshakes.
module tb_mont_arbiter;
    localparam int W = 381;

    typedef struct packed {
        logic         ch;
        logic [W-1:0] res;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req0_m = '0;
    logic [W-1:0] req1_a = '0, req1_b = '0, req1_m = '0;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [W-1:0] rsp_result;
    logic         mm_start;
    logic [W-1:0] mm_a, mm_b, mm_m;
    logic [W-1:0] mm_result = '0;
    logic         mm_done = 1'b0;
    logic         mm_out_read;
`ifdef MONT_ARB_STATS_EN
    logic [31:0]  stat_ops0, stat_ops1, stat_busy;
`endif

    int checks = 0;
    int errors = 0;
    int rsp_cnt = 0;
    int start_cnt = 0;
    exp_t exp_q[$];
    logic grants[$];

    logic         core_busy = 1'b0;
    int           core_cnt = 0;

    always #5 clk = ~clk;

    mont_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_m(req0_m),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_m(req1_m),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result),
        .mm_start(mm_start),
        .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_result(mm_result), .mm_done(mm_done),
        .mm_out_read(mm_out_read)
`ifdef MONT_ARB_STATS_EN
        ,
        .stat_ops0(stat_ops0), .stat_ops1(stat_ops1),
        .stat_busy(stat_busy)
`endif
    );

    // Core stub: done rises 10 cycles after start, held until read.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            core_busy <= 1'b0;
            core_cnt  <= 0;
            mm_done   <= 1'b0;
            mm_result <= '0;
        end else begin
            if (mm_start) begin
                core_busy <= 1'b1;
                core_cnt  <= 0;
                mm_result <= mm_a ^ mm_b ^ mm_m;
                start_cnt <= start_cnt + 1;
            end else if (core_busy) begin
                core_cnt <= core_cnt + 1;
                if (core_cnt == 9) begin
                    mm_done   <= 1'b1;
                    core_busy <= 1'b0;
                end
            end
            if (mm_done && mm_out_read) mm_done <= 1'b0;
        end
    end

    a_read_needs_done: assert property (
        @(posedge clk) disable iff (reset) mm_out_read |-> mm_done);
    a_done_seen: assert property (
        @(posedge clk) disable iff (reset)
        mm_done && !mm_out_read |=> mm_done);

    // Record accepts; the operands on the bus now are the ones latched
    // at the coming edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (req0_valid && req0_ready) begin
                exp_q.push_back('{1'b0, req0_a ^ req0_b ^ req0_m});
                grants.push_back(1'b0);
            end
            if (req1_valid && req1_ready) begin
                exp_q.push_back('{1'b1, req1_a ^ req1_b ^ req1_m});
                grants.push_back(1'b1);
            end
        end
    end

    // Monitor: compares every completed response with the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (rsp0_valid || rsp1_valid)) begin
            if (rsp0_valid && rsp1_valid) begin
                checks++;
                errors++;
                $display("FAIL both_rsp_valid at %0t", $time);
            end else if ((rsp0_valid && rsp0_ready) ||
                         (rsp1_valid && rsp1_ready)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp ch=%0d", rsp1_valid);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp1_valid !== e.ch) begin
                        errors++;
                        $display("FAIL rsp_channel got %0d want %0d",
                                 rsp1_valid, e.ch);
                    end
                    checks++;
                    if (rsp_result !== e.res) begin
                        errors++;
                        $display("FAIL rsp_result got %0h want %0h",
                                 rsp_result, e.res);
                    end
                    rsp_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic wait_grants(input int n);
        int k = 0;
        while (grants.size() < n && k < 300) begin
            tick();
            k++;
        end
        chk("grant_timeout", W'(grants.size()), W'(n));
    endtask

    task automatic wait_rsp(input int n);
        int k = 0;
        while (rsp_cnt < n && k < 500) begin
            tick();
            k++;
        end
        chk("rsp_timeout", W'(rsp_cnt), W'(n));
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req0_ready"}, W'(req0_ready), '0);
        chk({tag, "_req1_ready"}, W'(req1_ready), '0);
        chk({tag, "_rsp0_valid"}, W'(rsp0_valid), '0);
        chk({tag, "_rsp1_valid"}, W'(rsp1_valid), '0);
        chk({tag, "_mm_start"}, W'(mm_start), '0);
        chk({tag, "_mm_out_read"}, W'(mm_out_read), '0);
        chk({tag, "_mm_a"}, mm_a, '0);
        chk({tag, "_mm_m"}, mm_m, '0);
        chk({tag, "_rsp_result"}, rsp_result, '0);
    endtask

    initial begin
        int base;
        int sbase;
`ifdef MONT_ARB_STATS_EN
        logic [31:0] s0, s1;
`endif
        // Reset state
        req1_valid = 1'b1;
        repeat (3) tick();
        chk_idle_outputs("reset");
`ifdef MONT_ARB_STATS_EN
        chk("reset_stat_busy", W'(stat_busy), '0);
`endif
        req1_valid = 1'b0;
        reset = 1'b0;
        tick();

        // Single request from requester 0
        req0_a = W'(5);
        req0_b = W'(3);
        req0_m = W'(13);
        req0_valid = 1'b1;
        #1;
        chk("single_ready", W'(req0_ready), W'(1));
        tick();
        req0_valid = 1'b0;
        chk("single_start", W'(mm_start), W'(1));
        chk("single_mm_a", mm_a, W'(5));
        chk("single_mm_b", mm_b, W'(3));
        chk("single_mm_m", mm_m, W'(13));
        tick();
        chk("single_start_pulse", W'(mm_start), '0);
        wait_rsp(1);

        // Contention right after the first op: requester 0 wins
        // (it was granted before, but last_grant started at 1 and
        // the op above set it to 0, so force a fresh reset first).
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        req0_a = W'(32'h11);
        req0_b = W'(32'h22);
        req0_m = W'(32'h44);
        req1_a = W'(32'h100);
        req1_b = W'(32'h200);
        req1_m = W'(32'h401);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("cont_ready0", W'(req0_ready), W'(1));
        chk("cont_ready1", W'(req1_ready), '0);
        wait_grants(2);
        req0_valid = 1'b0;
        wait_grants(3);
        req1_valid = 1'b0;
        chk("cont_grant_a", W'(grants[1]), '0);
        chk("cont_grant_b", W'(grants[2]), W'(1));
        wait_rsp(3);

        // Fairness: both held valid for six ops
        base = grants.size();
`ifdef MONT_ARB_STATS_EN
        s0 = stat_ops0;
        s1 = stat_ops1;
`endif
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_grants(base + 6);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 6; i++)
            chk($sformatf("fair_grant%0d", i),
                W'(grants[base+i]), W'(i % 2));
        wait_rsp(9);
`ifdef MONT_ARB_STATS_EN
        tick();
        chk("stat_ops0", W'(stat_ops0 - s0), W'(3));
        chk("stat_ops1", W'(stat_ops1 - s1), W'(3));
`endif

        // Backpressure on requester 0 with requester 1 waiting
        rsp0_ready = 1'b0;
        sbase = start_cnt;
        req0_a = W'(32'h7);
        req0_b = W'(32'h70);
        req0_m = W'(32'h700);
        req0_valid = 1'b1;
        wait_grants(base + 7);
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        begin
            int k = 0;
            while (!rsp0_valid && k < 100) begin
                tick();
                k++;
            end
        end
        for (int i = 0; i < 20; i++) begin
            chk("bp_rsp0_valid", W'(rsp0_valid), W'(1));
            chk("bp_rsp_result", rsp_result, W'(32'h777));
            chk("bp_req1_ready", W'(req1_ready), '0);
            tick();
        end
        chk("bp_one_start", W'(start_cnt - sbase), W'(1));
        rsp0_ready = 1'b1;
        wait_grants(base + 8);
        req1_valid = 1'b0;
        wait_rsp(11);

        // Operand isolation
        req0_a = W'(32'h1234);
        req0_b = W'(32'h0F0F);
        req0_m = W'(32'h8001);
        req0_valid = 1'b1;
        wait_grants(base + 9);
        req0_valid = 1'b0;
        req0_a = W'(32'hFFFF);
        chk("iso_mm_a", mm_a, W'(32'h1234));
        repeat (3) tick();
        chk("iso_mm_a_later", mm_a, W'(32'h1234));
        wait_rsp(12);

        // Reset while the core is busy
        req0_a = W'(32'h55);
        req0_valid = 1'b1;
        wait_grants(base + 10);
        req0_valid = 1'b0;
        chk("rst_start", W'(mm_start), W'(1));
        repeat (4) tick();
        reset = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk_idle_outputs("rst_wait");
        exp_q.delete();
        tick();
        reset = 1'b0;
        req1_a = W'(32'hA0);
        req1_b = W'(32'h0B);
        req1_m = W'(32'h300);
        #1;
        chk("rst_req1_ready", W'(req1_ready), W'(1));
        wait_grants(base + 11);
        req1_valid = 1'b0;
        wait_rsp(13);

        tick();
        chk("queue_empty", W'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
